// File: rtl/cpu_pkg.sv
// Shared register-file geometry and word/index types for the core.
package cpu_pkg;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int PEND_W   = 2;
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] xword_t;
endpackage

// File: rtl/pending_counter.sv
// Saturating up/down count of in-flight writes to one register.
// Latency: count updates one edge after inc/dec; flags are combinational from count.
// Backpressure: none internally; the owner stops inc when is_full, dec at zero pulses underflow.
module pending_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_zero,
    output logic         is_full,
    output logic         underflow
);

    assign is_zero   = (count == '0);
    assign is_full   = &count;
    assign underflow = dec & is_zero;

    // Simultaneous inc and dec cancel; both ends saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && !is_full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && !is_zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with two registered read ports and a pending-write scoreboard.
// Latency: reads 1 cycle with write-first bypass; busy and issue_ready are combinational.
// Backpressure: issue_ready drops when the destination's pending count is saturated.
module regfile_scoreboard #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int PEND_W   = cpu_pkg::PEND_W,
    parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_error
);

    localparam int                NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_REG);
    localparam logic [PEND_W-1:0] ONE  = PEND_W'(1);

    logic [DATA_W-1:0] regs [NREG];
    logic [PEND_W-1:0] cnt  [NREG];
    logic [NREG-1:0]   claim_v, rel_v, zero_v, full_v, unf_v;
    logic              wr_en, claim;

    // A write-back is both the data write and the release of its claim.
    assign wr_en = wb_reg_write && (wb_reg != ZIDX);

    assign issue_ready = !((issue_rd != ZIDX) && full_v[issue_rd]
                           && !(wr_en && (wb_reg == issue_rd)));
    assign claim       = issue_valid && issue_ready && (issue_rd != ZIDX);

    always_comb begin
        claim_v = '0;
        rel_v   = '0;
        if (claim) claim_v[issue_rd] = 1'b1;
        if (wr_en) rel_v[wb_reg]     = 1'b1;
    end

    for (genvar g = 0; g < NREG; g++) begin : g_pend
        pending_counter #(.W(PEND_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (claim_v[g]),
            .dec       (rel_v[g]),
            .count     (cnt[g]),
            .is_zero   (zero_v[g]),
            .is_full   (full_v[g]),
            .underflow (unf_v[g])
        );
    end

    // A release landing this cycle retires one pending write, matching the read bypass.
    assign rs1_busy = (rs1_addr != ZIDX) && !zero_v[rs1_addr]
                      && !(wr_en && (wb_reg == rs1_addr) && (cnt[rs1_addr] == ONE));
    assign rs2_busy = (rs2_addr != ZIDX) && !zero_v[rs2_addr]
                      && !(wr_en && (wb_reg == rs2_addr) && (cnt[rs2_addr] == ONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
            wb_error <= 1'b0;
        end else begin
            if (wr_en) regs[wb_reg] <= wb_data;
            rs1_data <= (rs1_addr == ZIDX) ? '0 :
                        (wr_en && (wb_reg == rs1_addr)) ? wb_data : regs[rs1_addr];
            rs2_data <= (rs2_addr == ZIDX) ? '0 :
                        (wr_en && (wb_reg == rs2_addr)) ? wb_data : regs[rs2_addr];
            wb_error <= wb_error | (|unf_v);
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and random stimulus for regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard;
    import cpu_pkg::*;

    logic     clk = 1'b0;
    always #5 clk = ~clk;

    logic     reset;
    reg_idx_t rs1_addr, rs2_addr, issue_rd, wb_reg;
    xword_t   rs1_data, rs2_data, wb_data;
    logic     rs1_busy, rs2_busy, issue_valid, issue_ready, wb_reg_write, wb_error;

    regfile_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .wb_reg_write (wb_reg_write),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .wb_error     (wb_error)
    );

    int     vectors     = 0;
    int     miscompares = 0;
    localparam int PMAX = (1 << PEND_W) - 1;

    xword_t m_regs [32];
    int     m_cnt  [32];
    logic   m_err;
    xword_t m_rs1, m_rs2;
    bit     m_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_busy(input reg_idx_t a);
        int eff;
        if (a == reg_idx_t'(ZERO_REG)) return 1'b0;
        eff = m_cnt[a];
        if (wb_reg_write && wb_reg == a && eff > 0) eff = eff - 1;
        return eff != 0;
    endfunction

    function automatic logic exp_ready();
        if (issue_rd == reg_idx_t'(ZERO_REG)) return 1'b1;
        if (m_cnt[issue_rd] < PMAX) return 1'b1;
        return wb_reg_write && (wb_reg == issue_rd);
    endfunction

    task automatic model_edge();
        logic rel, clm;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_cnt[i]  = 0;
            end
            m_rs1 = '0;
            m_rs2 = '0;
            m_err = 1'b0;
        end else begin
            rel = wb_reg_write && (wb_reg != reg_idx_t'(ZERO_REG));
            clm = issue_valid && exp_ready() && (issue_rd != reg_idx_t'(ZERO_REG));
            m_rs1 = (rs1_addr == reg_idx_t'(ZERO_REG)) ? '0 :
                    (rel && wb_reg == rs1_addr) ? wb_data : m_regs[rs1_addr];
            m_rs2 = (rs2_addr == reg_idx_t'(ZERO_REG)) ? '0 :
                    (rel && wb_reg == rs2_addr) ? wb_data : m_regs[rs2_addr];
            if (rel && m_cnt[wb_reg] == 0) m_err = 1'b1;
            if (!(clm && rel && issue_rd == wb_reg)) begin
                if (clm) m_cnt[issue_rd]++;
                if (rel && m_cnt[wb_reg] > 0) m_cnt[wb_reg]--;
            end
            if (rel) m_regs[wb_reg] = wb_data;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        #1;
        if (m_valid) begin
            chk("rs1_busy", 64'(rs1_busy), 64'(exp_busy(rs1_addr)));
            chk("rs2_busy", 64'(rs2_busy), 64'(exp_busy(rs2_addr)));
            chk("issue_ready", 64'(issue_ready), 64'(exp_ready()));
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("rs1_data", rs1_data, m_rs1);
        chk("rs2_data", rs2_data, m_rs2);
        chk("wb_error", 64'(wb_error), 64'(m_err));
        m_valid = 1'b1;
    endtask

    task automatic idle();
        reset        = 1'b0;
        issue_valid  = 1'b0;
        wb_reg_write = 1'b0;
    endtask

    function automatic reg_idx_t pick();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 9) return reg_idx_t'(ZERO_REG);
        if (r == 8) return reg_idx_t'($urandom_range(0, 31));
        return reg_idx_t'(r);
    endfunction

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_rd = '0; wb_reg_write = 1'b0;
        wb_reg = '0; wb_data = '0; rs1_addr = '0; rs2_addr = '0;
        @(negedge clk);
        tick();
        tick();
        idle();

        for (int a = 0; a < 32; a++) begin
            rs1_addr = reg_idx_t'(a);
            rs2_addr = reg_idx_t'(31 - a);
            tick();
        end
        chk("reset_ready", 64'(issue_ready), 64'd1);

        // Claim 5, then write it with a same-edge read for the bypass.
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        idle();
        wb_reg_write = 1'b1; wb_reg = 5'd5; wb_data = 64'hDEADBEEF_00000005; rs1_addr = 5'd5;
        tick();
        chk("bypass_rs1", rs1_data, 64'hDEADBEEF_00000005);
        idle();
        rs2_addr = 5'd5;
        tick();
        chk("stored_rs2", rs2_data, 64'hDEADBEEF_00000005);

        // Zero register: writes dropped, claims ignored, no error.
        wb_reg_write = 1'b1; wb_reg = 5'd31; wb_data = '1; rs1_addr = 5'd31;
        tick();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd31;
        tick();
        idle();
        #1;
        chk("zero_busy", 64'(rs1_busy), 64'd0);
        tick();
        chk("zero_read", rs1_data, 64'd0);
        chk("zero_no_err", 64'(wb_error), 64'd0);

        // RAW hazard on 7, cleared by a same-cycle write-back.
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        idle();
        rs1_addr = 5'd7;
        #1;
        chk("r7_busy", 64'(rs1_busy), 64'd1);
        tick();
        wb_reg_write = 1'b1; wb_reg = 5'd7; wb_data = 64'h1234;
        #1;
        chk("r7_wb_clear", 64'(rs1_busy), 64'd0);
        tick();
        chk("r7_data", rs1_data, 64'h1234);
        idle();

        // Saturate 9, then claim+release together keeps it saturated.
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick(); tick(); tick();
        #1;
        chk("r9_full", 64'(issue_ready), 64'd0);
        tick();
        wb_reg_write = 1'b1; wb_reg = 5'd9; wb_data = 64'h99;
        #1;
        chk("r9_ready_rel", 64'(issue_ready), 64'd1);
        tick();
        wb_reg_write = 1'b0;
        #1;
        chk("r9_still_full", 64'(issue_ready), 64'd0);
        idle();
        wb_reg_write = 1'b1; wb_reg = 5'd9;
        tick(); tick(); tick();
        idle();
        rs1_addr = 5'd9;
        #1;
        chk("r9_idle", 64'(rs1_busy), 64'd0);
        tick();

        // Unclaimed write-back to 12 raises a sticky error but still writes.
        wb_reg_write = 1'b1; wb_reg = 5'd12; wb_data = 64'hC0FFEE;
        tick();
        chk("r12_err", 64'(wb_error), 64'd1);
        idle();
        rs2_addr = 5'd12;
        tick();
        chk("r12_data", rs2_data, 64'hC0FFEE);
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd4;
        tick();
        chk("err_sticky", 64'(wb_error), 64'd1);

        // Reset with claims pending and live inputs in the reset cycle.
        reset = 1'b1; issue_rd = 5'd3; wb_reg_write = 1'b1; wb_reg = 5'd4;
        tick();
        idle();
        rs1_addr = 5'd3; rs2_addr = 5'd4;
        #1;
        chk("rst_busy1", 64'(rs1_busy), 64'd0);
        chk("rst_busy2", 64'(rs2_busy), 64'd0);
        tick();
        chk("rst_err", 64'(wb_error), 64'd0);

        for (int n = 0; n < 600; n++) begin
            reset        = ($urandom_range(0, 59) == 0);
            issue_valid  = ($urandom_range(0, 9) < 6);
            issue_rd     = pick();
            wb_reg_write = ($urandom_range(0, 9) < 4);
            wb_reg       = pick();
            wb_data      = {$urandom, $urandom};
            rs1_addr     = pick();
            rs2_addr     = pick();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
